// File: rtl/wb_text_buffer.sv
// Character text buffer: a 2048x8 dual-port RAM with a Wishbone register port, a video read
// port, and a clear/scroll engine that owns RAM port B while it runs.
module wb_text_buffer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  input  logic [10:0] char_addr,
  output logic [7:0]  char_data,
  output logic        busy
);

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 8;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [AW-1:0] LAST       = AW'(CELLS - 1);
  localparam logic [AW-1:0] FILL_FIRST = AW'(CELLS - COLS);
  localparam logic [AW-1:0] COPY_LAST  = AW'(CELLS - COLS - 1);
  localparam logic [AW-1:0] COLS_A     = AW'(COLS);
  localparam logic [AW-1:0] ONE        = AW'(1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_CUR_LO = 3'd1;
  localparam logic [2:0] A_CUR_HI = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_FILL   = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCR_RD, S_SCR_WR, S_SCR_FILL} state_t;

  // A single-row buffer has nothing to copy, so its scroll is fill only
  localparam state_t        S_SCR_START   = (ROWS > 1) ? S_SCR_RD : S_SCR_FILL;
  localparam logic [AW-1:0] SCR_FIRST_IDX = (ROWS > 1) ? AW'(0) : FILL_FIRST;

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_char_data, r_b_q, r_dat_o, r_fill, r_fill_lat;
  logic [AW-1:0] r_cursor, r_idx;
  logic          r_ack, r_rd_pend, r_autoscroll, r_busy;
  state_t        r_state;

  state_t        w_state_next;
  logic [AW-1:0] w_idx_next, w_b_addr;
  logic [DW-1:0] w_b_wdata, w_reg_rd;
  logic          w_b_we, w_busy, w_req, w_stall_reg, w_accept, w_bus_wr;
  logic          w_data_wr, w_data_rd, w_ctrl_wr, w_wrap, w_start_clear, w_start_scroll;

  function automatic logic [AW-1:0] f_clamp(input logic [AW-1:0] v);
    f_clamp = (v > LAST) ? LAST : v;
  endfunction

  // Bus decode; DATA accesses and CTRL writes wait for the engine to finish
  assign w_busy         = (r_state != S_IDLE);
  assign w_req          = wb_cyc_i & wb_stb_i & ~r_ack & ~r_rd_pend;
  assign w_stall_reg    = (wb_adr_i == A_DATA) | ((wb_adr_i == A_CTRL) & wb_we_i);
  assign w_accept       = w_req & ~(w_busy & w_stall_reg);
  assign w_bus_wr       = w_accept & wb_we_i;
  assign w_data_wr      = w_bus_wr & (wb_adr_i == A_DATA);
  assign w_data_rd      = w_accept & ~wb_we_i & (wb_adr_i == A_DATA);
  assign w_ctrl_wr      = w_bus_wr & (wb_adr_i == A_CTRL);
  assign w_wrap         = (r_cursor == LAST);
  assign w_start_clear  = w_ctrl_wr & wb_dat_i[0];
  assign w_start_scroll = (w_ctrl_wr & ~wb_dat_i[0] & wb_dat_i[1]) |
                          (w_data_wr & w_wrap & r_autoscroll);

  // Engine state register; reset lands directly in CLEAR so the clear runs on release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start_clear)       w_state_next = S_CLEAR;
                  else if (w_start_scroll) w_state_next = S_SCR_START;
      S_CLEAR:    if (r_idx == LAST)       w_state_next = S_IDLE;
      S_SCR_RD:   w_state_next = S_SCR_WR;
      S_SCR_WR:   w_state_next = (r_idx == COPY_LAST) ? S_SCR_FILL : S_SCR_RD;
      S_SCR_FILL: if (r_idx == LAST)       w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Port B ownership: bus at the cursor when idle, engine walking r_idx otherwise
  always_comb begin
    w_b_we     = 1'b0;
    w_b_addr   = r_cursor;
    w_b_wdata  = wb_dat_i;
    w_idx_next = r_idx;
    case (r_state)
      S_IDLE: begin
        w_b_we     = w_data_wr;
        w_idx_next = w_start_clear ? AW'(0) : SCR_FIRST_IDX;
      end
      S_CLEAR, S_SCR_FILL: begin
        w_b_we     = 1'b1;
        w_b_addr   = r_idx;
        w_b_wdata  = r_fill_lat;
        w_idx_next = r_idx + ONE;
      end
      S_SCR_RD: w_b_addr = r_idx + COLS_A;
      S_SCR_WR: begin
        w_b_we     = 1'b1;
        w_b_addr   = r_idx;
        w_b_wdata  = r_b_q;
        w_idx_next = (r_idx == COPY_LAST) ? FILL_FIRST : r_idx + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_b_we && !rst) r_mem[w_b_addr] <= w_b_wdata;
    r_b_q <= r_mem[w_b_addr];
  end

  // Video port: free-running one-cycle read, independent of the engine
  always_ff @(posedge clk) begin
    r_char_data <= r_mem[char_addr];
  end

  always_comb begin
    w_reg_rd = '0;
    case (wb_adr_i)
      A_CUR_LO: w_reg_rd = r_cursor[7:0];
      A_CUR_HI: w_reg_rd = {5'b0, r_cursor[10:8]};
      A_CTRL:   w_reg_rd = {5'b0, r_autoscroll, 2'b0};
      A_STATUS: w_reg_rd = {7'b0, w_busy};
      A_FILL:   w_reg_rd = r_fill;
      default:  w_reg_rd = '0;
    endcase
  end

  // Bus registers, cursor and fill; DATA reads take an extra cycle through r_b_q
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack        <= 1'b0;
      r_dat_o      <= '0;
      r_rd_pend    <= 1'b0;
      r_cursor     <= '0;
      r_fill       <= 8'h20;
      r_fill_lat   <= 8'h20;
      r_autoscroll <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_rd_pend) begin
        r_ack     <= 1'b1;
        r_dat_o   <= r_b_q;
        r_rd_pend <= 1'b0;
      end else if (w_accept) begin
        if (w_data_rd) begin
          r_rd_pend <= 1'b1;
        end else begin
          r_ack <= 1'b1;
          if (!wb_we_i) r_dat_o <= w_reg_rd;
        end
      end

      if (r_state == S_CLEAR && r_idx == LAST)
        r_cursor <= '0;
      else if (w_data_wr)
        r_cursor <= w_wrap ? (r_autoscroll ? FILL_FIRST : AW'(0)) : r_cursor + ONE;
      else if (w_bus_wr && wb_adr_i == A_CUR_LO)
        r_cursor <= f_clamp({r_cursor[10:8], wb_dat_i});
      else if (w_bus_wr && wb_adr_i == A_CUR_HI)
        r_cursor <= f_clamp({wb_dat_i[2:0], r_cursor[7:0]});

      if (w_bus_wr && wb_adr_i == A_FILL) r_fill <= wb_dat_i;
      if (w_ctrl_wr) r_autoscroll <= wb_dat_i[2];
      if (r_state == S_IDLE && w_state_next != S_IDLE) r_fill_lat <= r_fill;
    end
  end

  assign wb_dat_o  = r_dat_o;
  assign wb_ack_o  = r_ack;
  assign char_data = r_char_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_wb_text_buffer.sv
// Directed bench for wb_text_buffer: register vector table plus hand-written
// reset, clear, scroll, autoscroll-stall and video-port sequences.
module tb_wb_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [7:0]  wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic [10:0] char_addr;
  logic [7:0]  char_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  localparam int TIMEOUT = 10000;

  wb_text_buffer dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .char_addr(char_addr), .char_data(char_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                         input logic [7:0] exp, input int lat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // One Wishbone transaction; lat counts clock edges from strobe to visible ack
  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                         output logic [7:0] rdat, output int lat);
    bit done;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    lat = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      lat++;
      if (wb_ack_o || lat >= TIMEOUT) done = 1'b1;
    end
    rdat = wb_dat_o;
    if (!wb_ack_o) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: adr %0d got no ack within %0d cycles", adr, TIMEOUT);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [7:0] dat, input string name);
    logic [7:0] d; int lat;
    wb_xfer(1'b1, adr, dat, d, lat);
    check({name, "_lat"}, lat, 1);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [7:0] exp, input int exp_lat,
                    input string name);
    logic [7:0] d; int lat;
    wb_xfer(1'b0, adr, 8'h00, d, lat);
    check({name, "_lat"}, lat, exp_lat);
    check(name, d, exp);
  endtask

  task automatic vid(input logic [10:0] addr, input logic [7:0] exp, input string name);
    @(posedge clk); #1;
    char_addr = addr;
    @(posedge clk); #1;
    check(name, char_data, exp);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  // Pipelined video sweep over cells that hold 0x20 throughout the scroll
  task automatic video_sweep(output int errs);
    errs = 0;
    @(posedge clk); #1;
    char_addr = 11'd100;
    for (int i = 0; i < 1800; i++) begin
      @(posedge clk); #1;
      if (char_data !== 8'h20) errs++;
      char_addr = 11'(101 + i);
    end
  endtask

  initial begin
    int n, errs, lat;
    logic [7:0] d;

    rst = 1'b1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = '0; wb_dat_i = '0; char_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 0);

    // Release reset: clear engine runs for every cell
    rst = 1'b0;
    count_busy(n);
    check("init_clear_busy_cycles", n, 2000);
    vid(11'd0,    8'h20, "init_ram0");
    vid(11'd999,  8'h20, "init_ram999");
    vid(11'd1999, 8'h20, "init_ram1999");

    // Register vectors from the post-reset state
    add_vec(0, 3'd1, 8'h00, 8'h00, 1);
    add_vec(0, 3'd2, 8'h00, 8'h00, 1);
    add_vec(0, 3'd3, 8'h00, 8'h00, 1);
    add_vec(0, 3'd4, 8'h00, 8'h00, 1);
    add_vec(0, 3'd5, 8'h00, 8'h20, 1);
    add_vec(0, 3'd6, 8'h00, 8'h00, 1);
    add_vec(1, 3'd7, 8'h55, 8'h00, 1);
    add_vec(0, 3'd7, 8'h00, 8'h00, 1);
    add_vec(1, 3'd2, 8'h07, 8'h00, 1);
    add_vec(1, 3'd1, 8'hFF, 8'h00, 1);
    add_vec(0, 3'd1, 8'h00, 8'hCF, 1);
    add_vec(0, 3'd2, 8'h00, 8'h07, 1);
    add_vec(1, 3'd1, 8'h00, 8'h00, 1);
    add_vec(0, 3'd1, 8'h00, 8'h00, 1);
    add_vec(0, 3'd2, 8'h00, 8'h07, 1);
    add_vec(1, 3'd2, 8'h03, 8'h00, 1);
    add_vec(0, 3'd2, 8'h00, 8'h03, 1);
    add_vec(1, 3'd2, 8'h00, 8'h00, 1);
    add_vec(1, 3'd0, 8'h48, 8'h00, 1);
    add_vec(1, 3'd0, 8'h49, 8'h00, 1);
    add_vec(0, 3'd1, 8'h00, 8'h02, 1);
    add_vec(1, 3'd1, 8'h00, 8'h00, 1);
    add_vec(0, 3'd0, 8'h00, 8'h48, 2);
    add_vec(0, 3'd1, 8'h00, 8'h00, 1);
    add_vec(1, 3'd1, 8'h01, 8'h00, 1);
    add_vec(0, 3'd0, 8'h00, 8'h49, 2);
    add_vec(1, 3'd3, 8'h04, 8'h00, 1);
    add_vec(0, 3'd3, 8'h00, 8'h04, 1);
    add_vec(1, 3'd3, 8'h00, 8'h00, 1);
    add_vec(0, 3'd3, 8'h00, 8'h00, 1);
    add_vec(1, 3'd5, 8'h2E, 8'h00, 1);
    add_vec(0, 3'd5, 8'h00, 8'h2E, 1);
    add_vec(1, 3'd5, 8'h20, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, d, lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), d, vecs[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ack_pulse", i), wb_ack_o, 0);
    end

    vid(11'd0, 8'h48, "text_ram0");
    vid(11'd1, 8'h49, "text_ram1");
    vid(11'd2, 8'h20, "text_ram2");

    // Cycle without strobe must not be acknowledged
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_adr_i = 3'd4;
    errs = 0;
    repeat (3) begin @(posedge clk); #1; if (wb_ack_o) errs++; end
    wb_cyc_i = 1'b0;
    check("no_ack_without_stb", errs, 0);

    // Scroll: seed row 1 and the last cell, wrap cursor with autoscroll off
    wr(3'd2, 8'h00, "scr_hi"); wr(3'd1, 8'h50, "scr_lo"); wr(3'd0, 8'h41, "scr_d41");
    wr(3'd2, 8'h07, "scr_hi2"); wr(3'd1, 8'hCF, "scr_lo2"); wr(3'd0, 8'h42, "scr_d42");
    rd(3'd1, 8'h00, 1, "wrap_cur_lo");
    rd(3'd2, 8'h00, 1, "wrap_cur_hi");
    wr(3'd3, 8'h02, "scr_ctrl");
    fork
      count_busy(n);
      video_sweep(errs);
    join
    check("scroll_busy_cycles", n, 3920);
    check("video_sweep_errors", errs, 0);
    vid(11'd0,    8'h41, "scr_ram0");
    vid(11'd1,    8'h20, "scr_ram1");
    vid(11'd80,   8'h20, "scr_ram80");
    vid(11'd1919, 8'h42, "scr_ram1919");
    errs = 0;
    @(posedge clk); #1;
    char_addr = 11'd1920;
    for (int a = 1921; a <= 2000; a++) begin
      @(posedge clk); #1;
      if (char_data !== 8'h20) errs++;
      char_addr = 11'(a);
    end
    check("scr_last_row_fill", errs, 0);

    // Clear and scroll together: clear wins; FILL written mid-run applies next time
    wr(3'd2, 8'h01, "clr_hi"); wr(3'd1, 8'hF4, "clr_lo");
    wr(3'd5, 8'h2E, "clr_fill");
    wr(3'd3, 8'h03, "clr_ctrl");
    fork
      count_busy(n);
      wr(3'd5, 8'h21, "fill_during_clear");
    join
    check("clear_busy_cycles", n, 2000);
    rd(3'd1, 8'h00, 1, "clr_cur_lo");
    rd(3'd2, 8'h00, 1, "clr_cur_hi");
    rd(3'd3, 8'h00, 1, "clr_ctrl_rd");
    rd(3'd5, 8'h21, 1, "clr_fill_rd");
    vid(11'd0,    8'h2E, "clr_ram0");
    vid(11'd1000, 8'h2E, "clr_ram1000");
    vid(11'd1919, 8'h2E, "clr_ram1919");
    vid(11'd1999, 8'h2E, "clr_ram1999");

    // Autoscroll wrap, then a DATA write stalls until the scroll ends
    wr(3'd5, 8'h20, "as_fill");
    wr(3'd3, 8'h04, "as_ctrl");
    rd(3'd3, 8'h04, 1, "as_ctrl_rd");
    wr(3'd2, 8'h07, "as_hi"); wr(3'd1, 8'hCF, "as_lo");
    wr(3'd0, 8'h5A, "as_d5a");
    rd(3'd1, 8'h80, 1, "as_cur_lo_busy");
    rd(3'd2, 8'h07, 1, "as_cur_hi_busy");
    rd(3'd4, 8'h01, 1, "as_status_busy");
    wb_xfer(1'b1, 3'd0, 8'h5B, d, lat);
    check("stalled_write_lat_range", (lat >= 3890 && lat <= 3920), 1);
    check("stalled_write_busy_at_ack", busy, 0);
    rd(3'd1, 8'h81, 1, "as_cur_after");
    vid(11'd0,    8'h2E, "as_ram0");
    vid(11'd1919, 8'h5A, "as_ram1919");
    vid(11'd1920, 8'h5B, "as_ram1920");
    vid(11'd1999, 8'h20, "as_ram1999");

    // Reset during a clear aborts it; the restarted clear uses the reset fill
    wr(3'd5, 8'h21, "rr_fill");
    wr(3'd3, 8'h01, "rr_ctrl");
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", wb_ack_o, 0);
    check("midrst_dat", wb_dat_o, 0);
    rst = 1'b0;
    count_busy(n);
    check("midrst_clear_busy_cycles", n, 2000);
    rd(3'd5, 8'h20, 1, "midrst_fill");
    rd(3'd3, 8'h00, 1, "midrst_ctrl");
    rd(3'd1, 8'h00, 1, "midrst_cur_lo");
    vid(11'd0,    8'h20, "midrst_ram0");
    vid(11'd1000, 8'h20, "midrst_ram1000");
    vid(11'd1999, 8'h20, "midrst_ram1999");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_text_buffer.md
WB_TEXT_BUFFER -- requirements
Module: wb_text_buffer

Interface
REQ-001 Parameters SHALL be: COLS, default 80, characters per row; ROWS, default 25, rows held; CELLS = COLS*ROWS, which must be ≤ 2048.
REQ-002 Port clk, input, 1 bit: single clock for all logic.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port wb_cyc_i, input, 1 bit: Wishbone cycle.
REQ-005 Port wb_stb_i, input, 1 bit: Wishbone strobe.
REQ-006 Port wb_we_i, input, 1 bit: Wishbone write enable.
REQ-007 Port wb_adr_i, input, 3 bits: register select.
REQ-008 Port wb_dat_i, input, 8 bits: write data.
REQ-009 Port wb_dat_o, output, 8 bits: read data.
REQ-010 Port wb_ack_o, output, 1 bit: Wishbone acknowledge.
REQ-011 Port char_addr, input, 11 bits: video read address.
REQ-012 Port char_data, output, 8 bits: character code, registered.
REQ-013 Port busy, output, 1 bit: a clear or scroll engine is active.

Function
REQ-014 Storage SHALL be a 2048x8 dual-port RAM: port A for video reads, port B for the bus and engine.
REQ-015 Port A SHALL return char_data exactly 1 cycle after char_addr, for any address 0-2047, and SHALL never stall.
REQ-016 Register map: 0 DATA; 1 CURSOR_LO (bits [7:0]); 2 CURSOR_HI (bits [2:0]); 3 CTRL; 4 STATUS (bit0 busy); 5 FILL; 6-7 read 0, writes ignored.
REQ-017 CTRL bits: [0] clear, write-1 self-clearing; [1] scroll, write-1 self-clearing; [2] autoscroll, sticky; CTRL reads return {5'b0, autoscroll, 2'b0}.
REQ-018 Ack SHALL be a single-cycle pulse, and only when wb_cyc_i&wb_stb_i is set.
REQ-019 Ack timing:
- register writes and non-DATA reads: ack 1 cycle after strobe;
- DATA reads: ack 2 cycles after strobe, returning RAM[cursor].
REQ-020 While busy=1, writes to DATA or CTRL and DATA reads SHALL be stalled (no ack) until the engine returns to IDLE, then serviced normally; other registers are serviced without stall.
REQ-021 A DATA write SHALL store wb_dat_i at the cursor, then advance the cursor by 1.
REQ-022 Cursor wrap at CELLS-1:
- autoscroll=0: cursor wraps to 0;
- autoscroll=1: start a scroll, and set cursor to (ROWS-1)*COLS.
REQ-023 A cursor write ≥ CELLS SHALL clamp to CELLS-1; a HI write combines with the existing LO bits.
REQ-024 Engine FSM states: IDLE, CLEAR, SCR_RD, SCR_WR, SCR_FILL.
REQ-025 CLEAR SHALL write FILL to cells 0..CELLS-1, one per cycle (CELLS cycles), then go to IDLE, leaving cursor = 0.
REQ-026 Scroll copy: for i = 0..CELLS-COLS-1, SCR_RD reads cell i+COLS and the next SCR_WR writes it to cell i (2 cycles per cell).
REQ-027 Scroll fill: SCR_FILL writes FILL to cells CELLS-COLS..CELLS-1, one per cycle, then goes to IDLE. Total scroll time = 2*(CELLS-COLS)+COLS cycles.
REQ-028 busy SHALL be 1 in every state except IDLE, and SHALL deassert in the first IDLE cycle.
REQ-029 If clear and scroll are written together, clear SHALL take priority and the scroll is dropped.
REQ-030 Cells CELLS..2047 SHALL never be written by the engine or the bus.
REQ-031 The FILL value is sampled at engine start; FILL writes during an engine run take effect on the next run.

Reset
REQ-032 On rst: wb_ack_o=0, wb_dat_o=0, cursor=0, FILL=0x20, autoscroll=0, any pending access dropped.
REQ-033 The cycle after rst deasserts, the engine SHALL enter CLEAR (busy=1 for CELLS cycles).
REQ-034 rst asserted mid-engine SHALL abort the engine immediately; the restarted clear defines the RAM contents.
REQ-035 char_data is undefined until the first read after reset.

Verification
REQ-036 Post-reset: release rst → busy=1 for 2000 cycles; then reads at char_addr 0, 999, 1999 → 0x20, 1 cycle later.
REQ-037 Text write: cursor=0; DATA writes 0x48, 0x49 → RAM[0]=0x48, RAM[1]=0x49, cursor=2; each write ack 1 cycle after strobe.
REQ-038 Scroll: RAM[80]=0x41, RAM[1999]=0x42; CTRL=0x02 → busy=1 for 3920 cycles; then RAM[0]=0x41, RAM[1919]=0x42, RAM[1920..1999]=0x20.
REQ-039 Autoscroll wrap: CTRL=0x04, cursor=1999; DATA write 0x5A → scroll starts, cursor=1920; the next DATA write stalls until busy=0.
REQ-040 Boundaries: CURSOR_HI=7, CURSOR_LO=0xFF → cursor reads 1999. Simultaneous clear+scroll (CTRL=0x03) → clear only, 2000 cycles. Read of address 6 → 0x00.
REQ-041 Video port under load: char_addr sweeps 0-2047 during a scroll → char_data always follows with 1-cycle latency, with no stall or glitch.
